// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_arb_pkg
//  Description : Shared constants and state encoding for the UART transmit
//                arbiter. It holds the arbiter FSM encoding, the default
//                requester count and the byte width.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_arb_pkg;

    localparam int c_BYTE_W          = 8;
    localparam int c_DEFAULT_NUM_REQ = 4;

    // Arbiter FSM encoding
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_LOAD  = 2'd1;
    localparam logic [1:0] c_START = 2'd2;
    localparam logic [1:0] c_WAIT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = c_IDLE,
        ST_LOAD  = c_LOAD,
        ST_START = c_START,
        ST_WAIT  = c_WAIT
    } arb_state_t;

endpackage : uart_arb_pkg
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
//  Module      : rr_select
//  Description : Combinational rotating-priority picker. Searches the request
//                vector starting at (i_last_idx + 1) mod NUM_REQ, wrapping,
//                and returns the first set position.
//  Ports       : i_req      - request vector
//                i_last_idx - index served most recently
//                o_found    - at least one request is set
//                o_idx      - binary index of the winner
//                o_onehot   - one-hot form of the winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_select #(
    parameter int NUM_REQ   = 4,
    parameter int IDX_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]   i_req,
    input  logic [IDX_WIDTH-1:0] i_last_idx,
    output logic                 o_found,
    output logic [IDX_WIDTH-1:0] o_idx,
    output logic [NUM_REQ-1:0]   o_onehot
);

    always_comb begin
        int w_pos;
        o_found  = 1'b0;
        o_idx    = '0;
        o_onehot = '0;
        w_pos    = 0;
        // k = 1 visits the slot just after the last winner; k = NUM_REQ
        // revisits the last winner itself, so a lone requester is still served.
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_pos = (int'(i_last_idx) + k) % NUM_REQ;
            if (!o_found && i_req[w_pos]) begin
                o_found         = 1'b1;
                o_idx           = IDX_WIDTH'(w_pos);
                o_onehot[w_pos] = 1'b1;
            end
        end
    end

endmodule : rr_select
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Packet-granular round-robin arbiter sharing one uart_tx
//                among NUM_REQ byte-stream requesters. A grant is held from
//                the first byte through the byte flagged last, so packets
//                never interleave on the serial line.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                req_valid/data/last - per-requester byte stream (8 bits each)
//                req_ack           - one-cycle pulse, byte consumed
//                grant, busy       - current owner (one-hot) / owner present
//                tx_data, tx_start - to uart_tx
//                tx_ready          - from uart_tx (idle)
//                timeout_pulse     - only with UART_ARB_TIMEOUT_EN
//  Options     : `define UART_ARB_TIMEOUT_EN releases a grant whose owner
//                stalls for TIMEOUT_CYCLES mid-packet.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = c_DEFAULT_NUM_REQ,
    parameter int IDX_WIDTH      = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [c_BYTE_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [c_BYTE_W-1:0]       tx_data,
    output logic                      tx_start,
    input  logic                      tx_ready
`ifdef UART_ARB_TIMEOUT_EN
    ,
    output logic                      timeout_pulse
`endif
);

    // Elaboration-time parameter sanity check
    if (NUM_REQ < 2 || NUM_REQ > 8 || IDX_WIDTH < $clog2(NUM_REQ) ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("uart_tx_arbiter: illegal parameter combination");
    end

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [NUM_REQ-1:0]    r_grant;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [IDX_WIDTH-1:0]  r_last_idx;
    logic                  r_last_flag;
    logic [c_BYTE_W-1:0]   r_tx_data;

    logic                  w_sel_found;
    logic [IDX_WIDTH-1:0]  w_sel_idx;
    logic [NUM_REQ-1:0]    w_sel_onehot;

    logic                  w_cur_valid;
    logic                  w_cur_last;
    logic [c_BYTE_W-1:0]   w_cur_byte;

    logic                  w_take;
    logic                  w_ack;
    logic                  w_release;
    logic                  w_timeout;

    rr_select #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_select (
        .i_req      (req_valid),
        .i_last_idx (r_last_idx),
        .o_found    (w_sel_found),
        .o_idx      (w_sel_idx),
        .o_onehot   (w_sel_onehot)
    );

    // Owner's stream as seen this cycle
    always_comb begin
        w_cur_valid = 1'b0;
        w_cur_last  = 1'b0;
        w_cur_byte  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_idx == IDX_WIDTH'(i)) begin
                w_cur_valid = req_valid[i];
                w_cur_last  = req_last[i];
                w_cur_byte  = req_data[i*c_BYTE_W +: c_BYTE_W];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [31:0] r_stall_cnt;
    logic        r_timeout_pulse;

    // Fires on the TIMEOUT_CYCLES-th consecutive stalled LOAD cycle
    assign w_timeout = (r_state == ST_LOAD) && !w_cur_valid &&
                       (r_stall_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt     <= '0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_timeout_pulse <= w_timeout;
            if (r_state == ST_LOAD && !w_cur_valid && !w_timeout)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            else
                r_stall_cnt <= '0;
        end
    end

    assign timeout_pulse = r_timeout_pulse;
`else
    assign w_timeout = 1'b0;
`endif

    // Next state and Mealy outputs
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_ack       = 1'b0;
        w_release   = 1'b0;
        req_ack     = '0;
        tx_start    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // uart_tx is not reset, so never arbitrate while it is busy
                if (tx_ready && w_sel_found) begin
                    w_take      = 1'b1;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_cur_valid) begin
                    w_ack       = 1'b1;
                    req_ack     = r_grant;
                    w_state_nxt = ST_START;
                end else if (w_timeout) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                tx_start    = 1'b1;
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_ready) begin
                    if (r_last_flag) begin
                        w_release   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_idx       <= '0;
            r_last_idx  <= IDX_WIDTH'(NUM_REQ - 1);
            r_last_flag <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take) begin
                r_grant <= w_sel_onehot;
                r_idx   <= w_sel_idx;
            end
            if (w_ack) begin
                r_tx_data   <= w_cur_byte;
                r_last_flag <= w_cur_last;
            end
            if (w_release) begin
                r_grant    <= '0;
                r_last_idx <= r_idx;
            end
        end
    end

    assign grant   = r_grant;
    assign busy    = |r_grant;
    assign tx_data = r_tx_data;

endmodule : uart_tx_arbiter
`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Packet-granular round-robin arbiter that shares one uart_tx transmitter among NUM_REQ byte-stream requesters (e.g. VGA status echo, command responder, debug dump). Each grant is held for one whole packet (up to and including the byte flagged last), so packets never interleave on the serial line. The block sits between the requesters and uart_tx, drives uart_tx data/start, and paces transfers with uart_tx ready.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
IDX_WIDTH, 2, width of grant index; must be >= clog2(NUM_REQ)
TIMEOUT_CYCLES, 1000000, stall limit in clk cycles for a granted requester mid-packet (used only with the optional feature)

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  NUM_REQ  requester i has a byte on req_data[8i+7:8i]
req_data  in  8*NUM_REQ  packed request bytes
req_last  in  NUM_REQ  byte presented by requester i ends its packet
req_ack  out  NUM_REQ  one-cycle pulse: byte from requester i consumed
grant  out  NUM_REQ  one-hot owner of the transmitter; zero when idle
busy  out  1  high while any grant is held
tx_data  out  8  byte to uart_tx data
tx_start  out  1  to uart_tx start
tx_ready  in  1  from uart_tx ready

Behaviour:
- Reset: tx_start=0, tx_data=8'h00, req_ack=0, grant=0, busy=0, state=IDLE, last_idx=NUM_REQ-1 (requester 0 has first priority). uart_tx has no reset; the arbiter never arbitrates until it sees tx_ready=1.
- States: IDLE, LOAD, START, WAIT.
- IDLE: when tx_ready=1 and any req_valid: choose the first valid index searching from (last_idx+1) mod NUM_REQ upward with wrap; register grant/idx, busy=1 -> LOAD. Otherwise stay.
- LOAD: if req_valid[idx]=1: tx_data<=byte[idx], last_flag<=req_last[idx], req_ack[idx]=1 for this cycle only -> START. If req_valid[idx]=0, hold the grant and wait; no other requester is served.
- START: tx_start=1 for exactly one cycle (uart_tx latches data while idle) -> WAIT.
- WAIT: tx_start=0; when tx_ready=1 (end of frame), go to IDLE if last_flag=1 (grant=0, busy=0, last_idx<=idx), else LOAD.
- Latency: request valid in IDLE -> grant next cycle; ack -> tx_start next cycle; one byte per uart frame plus 3 clk overhead.
- req_valid deasserting while not granted is legal. Changing req_data of a granted requester before its ack is legal; the byte sampled in the ack cycle is sent.
- Simultaneous valid from all requesters: strict rotation, with one packet per requester per round.
- Single-requester case: repeated packets from the same requester are allowed back-to-back after one IDLE cycle.
- req_last is ignored unless it is sampled with an acked byte.
- rst mid-frame: the arbiter returns to reset values immediately; the in-flight uart frame completes on its own; the next grant waits for tx_ready=1.

Optional Feature:
Macro UART_ARB_TIMEOUT_EN.
- Defined: a 32-bit stall counter runs in LOAD while req_valid[idx]=0 and clears on every ack. On reaching TIMEOUT_CYCLES, the arbiter releases the grant, sets last_idx<=idx and goes to IDLE. It also raises the output timeout_pulse (1 bit, reset 0) for one cycle.
- Undefined: the counter and timeout_pulse port do not exist, and the grant is held indefinitely until req_last.

Decomposition:
- Package uart_arb_pkg: state encoding localparams (IDLE=2'd0, LOAD=2'd1, START=2'd2, WAIT=2'd3), default NUM_REQ, and the byte width constant 8.
- One sub-module, rr_select: combinational rotating-priority picker (inputs: req vector and last_idx; outputs: found, idx, one-hot).
- FSM, data mux and timeout stay in the top module.

Test Plan:
- Bench configuration: uart_tx instantiated with CLOCK=110 and BAUD=10, giving COUNT_MAX=11.
- Single requester: req 0 sends 3 bytes 0x41, 0x42, 0x43 with last on 0x43. The serial line decodes as 0x41, 0x42, 0x43 in order, with 3 req_ack pulses and grant=4'b0001 throughout; after the final frame ends, grant=0 and busy=0.
- Contention: all four requesters send one 2-byte packet, with reqs 0..3 asserted in the same cycle after reset. Packets come out in order 0, 1, 2, 3, each packet is contiguous, and grant steps 0001->0010->0100->1000.
- Fairness wrap: last_idx=2, then reqs 1 and 3 request -> req 3 is granted first and req 1 second.
- Stall: the granted requester drops req_valid for 500 cycles mid-packet while req 2 is valid. Grant stays on the stalled requester, req 2 gets no ack, and no tx_start occurs.
- Reset mid-frame: assert rst for 1 cycle during bit 4 of a frame. All outputs go to reset values the next cycle; the frame still finishes on tx; the next grant appears only after tx_ready=1.
- With UART_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=50: the stalled requester is released after 50 cycles, with a one-cycle timeout_pulse and the next valid requester granted.
